// File: rtl/hex_word_assembler.sv
// Hex word assembler: packs decoded hex digits into a word ended by CR/LF.
// Parse errors, digit overflow and idle timeouts raise a one-cycle oERR.
module hex_word_assembler #(
    parameter int DIGITS  = 4,
    parameter int TIMEOUT = 1000000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  iVALID,
    input  logic [7:0]            iCHR,
    input  logic [3:0]            iNIB,
    input  logic                  iDEC_ERR,
    output logic                  oVALID,
    output logic [4*DIGITS-1:0]   oWORD,
    output logic [2:0]            oCNT,
    output logic                  oERR
);

    localparam int          W    = 4 * DIGITS;
    localparam logic [31:0] TLIM = 32'(TIMEOUT - 1);
    localparam logic [7:0]  DMAX = 8'(DIGITS);

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        DISCARD
    } state_t;

    state_t      state;
    logic [W-1:0] acc;
    logic [7:0]  cnt;
    logic [31:0] tmo;

    logic is_term;
    logic is_hex;
    logic full;
    logic tmo_hit;

    // Terminators are recognised from the raw character alone.
    assign is_term = (iCHR == 8'h0D) || (iCHR == 8'h0A);
    assign is_hex  = ~iDEC_ERR;
    assign full    = (cnt >= DMAX);
    assign tmo_hit = (tmo == TLIM);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            acc    <= '0;
            cnt    <= '0;
            tmo    <= '0;
            oVALID <= 1'b0;
            oERR   <= 1'b0;
            oWORD  <= '0;
            oCNT   <= '0;
        end else begin
            oVALID <= 1'b0;
            oERR   <= 1'b0;
            if (iVALID) begin
                tmo <= '0;
                unique case (state)
                    IDLE: begin
                        if (is_term) begin
                            state <= IDLE;
                        end else if (is_hex) begin
                            acc   <= W'(iNIB);
                            cnt   <= 8'd1;
                            state <= ACC;
                        end else begin
                            oERR  <= 1'b1;
                            state <= DISCARD;
                        end
                    end
                    ACC: begin
                        if (is_term) begin
                            oVALID <= 1'b1;
                            oWORD  <= acc;
                            oCNT   <= cnt[2:0];
                            state  <= IDLE;
                        end else if (is_hex && !full) begin
                            acc <= (acc << 4) | W'(iNIB);
                            cnt <= cnt + 8'd1;
                        end else begin
                            oERR  <= 1'b1;
                            state <= DISCARD;
                        end
                    end
                    DISCARD: begin
                        if (is_term)
                            state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == ACC) begin
                if (tmo_hit) begin
                    oERR  <= 1'b1;
                    state <= IDLE;
                    tmo   <= '0;
                end else begin
                    tmo <= tmo + 32'd1;
                end
            end else begin
                tmo <= '0;
            end
        end
    end

endmodule

// File: tb/tb_hex_word_assembler.sv
// Directed bench for hex_word_assembler with a reference model feeding
// an expected-output queue checked by a cycle-accurate monitor.
module tb_hex_word_assembler;

    localparam int         TMO = 8;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] LF  = 8'h0A;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iVALID;
    logic [7:0]  iCHR;
    logic [3:0]  iNIB;
    logic        iDEC_ERR;
    logic        oVALID;
    logic [15:0] oWORD;
    logic [2:0]  oCNT;
    logic        oERR;

    hex_word_assembler #(.DIGITS(4), .TIMEOUT(TMO)) dut (
        .CLK(CLK), .RST(RST), .iVALID(iVALID), .iCHR(iCHR),
        .iNIB(iNIB), .iDEC_ERR(iDEC_ERR), .oVALID(oVALID),
        .oWORD(oWORD), .oCNT(oCNT), .oERR(oERR)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          v;
        bit          e;
        logic [15:0] w;
        logic [2:0]  c;
        int          due;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   pcnt   = 0;

    always @(posedge CLK) pcnt <= pcnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model state
    int          mst = 0;
    logic [15:0] macc = '0;
    int          mcnt = 0;
    int          midle = 0;
    logic [15:0] lastw = '0;
    logic [2:0]  lastc = '0;

    function automatic logic [4:0] dec(input logic [7:0] c);
        if (c >= "0" && c <= "9") return {1'b0, 4'(c - "0")};
        if (c >= "A" && c <= "F") return {1'b0, 4'(c - "A" + 10)};
        if (c >= "a" && c <= "f") return {1'b0, 4'(c - "a" + 10)};
        return 5'h10;
    endfunction

    task automatic push(input bit v, input logic [15:0] w,
                        input logic [2:0] c);
        exp_t e;
        e.v = v; e.e = !v; e.w = w; e.c = c; e.due = pcnt;
        q.push_back(e);
    endtask

    task automatic model(input logic [7:0] c);
        logic [4:0] d;
        bit term;
        d = dec(c);
        term = (c == CR) || (c == LF);
        midle = 0;
        case (mst)
            0: if (term) mst = 0;
               else if (!d[4]) begin macc = 16'(d[3:0]); mcnt = 1; mst = 1; end
               else begin push(0, '0, '0); mst = 2; end
            1: if (term) begin
                   push(1, macc, 3'(mcnt));
                   lastw = macc; lastc = 3'(mcnt); mst = 0;
               end else if (!d[4] && mcnt < 4) begin
                   macc = {macc[11:0], d[3:0]}; mcnt++;
               end else begin push(0, '0, '0); mst = 2; end
            default: if (term) mst = 0;
        endcase
    endtask

    task automatic send(input logic [7:0] c);
        logic [4:0] d;
        d = dec(c);
        iVALID = 1'b1; iCHR = c; iNIB = d[3:0]; iDEC_ERR = d[4];
        @(posedge CLK); #1;
        model(c);
        iVALID = 1'b0; iCHR = '0; iNIB = '0; iDEC_ERR = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge CLK); #1;
            if (mst == 1) begin
                midle++;
                if (midle == TMO) begin
                    push(0, '0, '0); mst = 0; midle = 0;
                end
            end
        end
    endtask

    task automatic do_reset();
        RST = 1'b1;
        #1;
        chk("rst_valid", 32'(oVALID), 0);
        chk("rst_err", 32'(oERR), 0);
        chk("rst_word", 32'(oWORD), 0);
        chk("rst_cnt", 32'(oCNT), 0);
        mst = 0; mcnt = 0; macc = '0; midle = 0;
        lastw = '0; lastc = '0;
        @(posedge CLK); #1;
        RST = 1'b0;
    endtask

    always @(negedge CLK) begin
        if (!RST) begin
            while (q.size() > 0 && q[0].due < pcnt) begin
                chk("missing_out", 32'(pcnt), 32'(q[0].due));
                void'(q.pop_front());
            end
            if (oVALID || oERR) begin
                chk("excl", 32'(oVALID & oERR), 0);
                if (q.size() == 0) begin
                    chk("spurious_out", {30'd0, oVALID, oERR}, 0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("kind", {30'd0, oVALID, oERR}, {30'd0, e.v, e.e});
                    chk("latency", 32'(pcnt), 32'(e.due));
                    if (e.v) begin
                        chk("word", 32'(oWORD), 32'(e.w));
                        chk("cnt", 32'(oCNT), 32'(e.c));
                    end
                end
            end
        end
    end

    initial begin
        RST = 1'b1; iVALID = 1'b0; iCHR = '0; iNIB = '0; iDEC_ERR = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        do_reset();

        send_str("1aF3"); send(CR);
        idle(3);
        send(CR); send(LF);
        idle(2);
        send_str("7"); send(LF); send(CR);
        idle(3);
        send_str("12345"); send(CR);
        send_str("B"); send(CR);
        idle(3);
        send_str("4G2"); send(CR);
        send_str("9"); send(CR);
        idle(3);
        send_str("Z"); send_str("ab"); send(LF);
        send_str("c0"); send(CR);
        idle(3);

        send_str("5");
        idle(TMO + 2);
        send(CR);
        idle(2);
        send_str("5");
        idle(TMO - 1);
        send(CR);
        idle(3);
        send_str("E");
        idle(TMO + 3);

        send_str("AB");
        do_reset();
        send(CR);
        send_str("C"); send(CR);
        idle(4);

        chk("queue_empty", 32'(q.size()), 0);
        chk("hold_word", 32'(oWORD), 32'(lastw));
        chk("hold_cnt", 32'(oCNT), 32'(lastc));
        chk("final_word", 32'(lastw), 32'h000C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hex_word_assembler.md
HEX_WORD_ASSEMBLER -- requirements
Module: hex_word_assembler

Interface
REQ-001 Parameter DIGITS, default 4, SHALL set the maximum hex digits per word; the word width is 4*DIGITS.
REQ-002 Parameter TIMEOUT, default 1000000, SHALL set the idle-clock limit inside a partial word; 32-bit counter.
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 RST  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 iVALID  input  1  SHALL qualify iCHR/iNIB/iDEC_ERR for one cycle; these are the character-to-nibble converter outputs, registered and aligned with the delayed character.
REQ-006 iCHR  input  8  SHALL carry the raw ASCII character matching iNIB.
REQ-007 iNIB  input  4  SHALL carry the decoded hex nibble.
REQ-008 iDEC_ERR  input  1  SHALL be 1 when iCHR is not 0-9/A-F/a-f.
REQ-009 oVALID  output  1  SHALL pulse for one cycle when a word completes.
REQ-010 oWORD  output  4*DIGITS  SHALL carry the assembled word; it holds until the next oVALID.
REQ-011 oCNT  output  3  SHALL carry the digit count of the word, valid with oVALID; it holds with oWORD.
REQ-012 oERR  output  1  SHALL pulse for one cycle on a parse error or timeout.

Function
REQ-013 The states SHALL be IDLE, ACC and DISCARD; inputs are examined only when iVALID=1.
REQ-014 A terminator SHALL be iCHR = 0x0D or 0x0A; terminator detection uses iCHR and ignores iDEC_ERR.
REQ-015 IDLE with a hex digit (iDEC_ERR=0): word accumulator = iNIB, count = 1, next state ACC.
REQ-016 IDLE with a terminator: no output and stay in IDLE, so empty lines and CR+LF pairs are silent.
REQ-017 IDLE with any other character: oERR pulse, next state DISCARD.
REQ-018 ACC with a hex digit and count < DIGITS: accumulator = {accumulator[4*DIGITS-5:0], iNIB} (shift left one nibble), count +1.
REQ-019 ACC with a hex digit and count = DIGITS (overflow): oERR pulse, next state DISCARD, accumulator unchanged.
REQ-020 ACC with a terminator: the next cycle oVALID=1, oWORD = accumulator (zero-extended on the left), oCNT = count; next state IDLE.
REQ-021 ACC with any other character: oERR pulse, next state DISCARD.
REQ-022 DISCARD: all characters are ignored until a terminator, which returns to IDLE with no output.
REQ-023 Output latency: oVALID/oERR SHALL assert exactly one clock after the iVALID cycle that caused them.
REQ-024 Timeout counter: cleared on every iVALID and in IDLE/DISCARD; in ACC, reaching TIMEOUT idle clocks SHALL give an oERR pulse and return to IDLE.
REQ-025 If iVALID and timeout expiry fall in the same cycle, the input SHALL win; the counter clears and the character is processed normally.
REQ-026 oVALID and oERR SHALL never be asserted in the same cycle.
REQ-027 Back-to-back iVALID on every clock SHALL be accepted without loss; there is no backpressure.

Reset
REQ-028 While RST=1: state IDLE; oVALID=0, oERR=0, oWORD=0, oCNT=0; accumulator, count and timeout counter are 0.
REQ-029 Reset asserted mid-word SHALL discard the partial word; no oVALID or oERR is generated after release.
REQ-030 The first iVALID after RST deasserts SHALL be processed from IDLE.

Verification
REQ-031 "1","a","F","3",CR -> one cycle later oVALID=1, oWORD=0x1AF3, oCNT=4; no oERR.
REQ-032 "7",LF,CR -> oVALID once with oWORD=0x0007, oCNT=1; the CR produces no output.
REQ-033 "12345",CR with DIGITS=4 -> oERR on the 5th digit, no oVALID, state IDLE after CR; then "B",CR -> oWORD=0x000B.
REQ-034 "4G2",CR -> oERR one cycle after "G", no oVALID; the following "9",CR -> oWORD=0x0009, oCNT=1.
REQ-035 TIMEOUT=8: "5", then 8 idle clocks -> oERR pulse, IDLE; iVALID on the 8th idle clock -> no timeout.
REQ-036 "AB", RST pulse, CR, "C",CR -> no output for the first CR; then oWORD=0x000C, oCNT=1.
